// File: rtl/mul_x_unit_if.sv
// mul_x_unit_if: issue-side and writeback-side channels of the iterative
// multiply execute pipe, bundled in one interface.
//
// Handshake rule, both channels: a transfer happens on a rising clk edge
// where the producer's *_val and the consumer's *_rdy are both 1. A producer
// holds its payload stable while *_val is 1 and *_rdy is 0. A producer never
// waits on *_rdy before raising *_val.
//
// Modports:
//   master - issue/writeback side (drives d_*, w_rdy; observes d_rdy, w_*)
//   slave  - the multiply unit    (drives d_rdy, w_*; observes d_*, w_rdy)
interface mul_x_unit_if #(
  parameter int p_seq_num_bits   = 5,
  parameter int p_phys_addr_bits = 6
);
  // issue channel
  logic                        d_val;
  logic                        d_rdy;
  logic [1:0]                  d_func;
  logic [31:0]                 d_op1;
  logic [31:0]                 d_op2;
  logic [31:0]                 d_pc;
  logic [4:0]                  d_waddr;
  logic [p_seq_num_bits-1:0]   d_seq_num;
  logic [p_phys_addr_bits-1:0] d_preg;
  logic [p_phys_addr_bits-1:0] d_ppreg;
  // writeback channel
  logic                        w_val;
  logic                        w_rdy;
  logic [31:0]                 w_wdata;
  logic                        w_wen;
  logic [31:0]                 w_pc;
  logic [4:0]                  w_waddr;
  logic [p_seq_num_bits-1:0]   w_seq_num;
  logic [p_phys_addr_bits-1:0] w_preg;
  logic [p_phys_addr_bits-1:0] w_ppreg;

  modport master (
    output d_val, d_func, d_op1, d_op2, d_pc, d_waddr, d_seq_num, d_preg, d_ppreg,
    input  d_rdy,
    input  w_val, w_wdata, w_wen, w_pc, w_waddr, w_seq_num, w_preg, w_ppreg,
    output w_rdy
  );

  modport slave (
    input  d_val, d_func, d_op1, d_op2, d_pc, d_waddr, d_seq_num, d_preg, d_ppreg,
    output d_rdy,
    output w_val, w_wdata, w_wen, w_pc, w_waddr, w_seq_num, w_preg, w_ppreg,
    input  w_rdy
  );
endinterface

// File: rtl/mul_x_unit.sv
// mul_x_unit: iterative RV32M multiply execute pipe (MUL/MULH/MULHSU/MULHU).
// Accepts one op on the issue channel, multiplies operand magnitudes with a
// shift-add datapath retiring p_bits_per_cycle multiplier bits per cycle,
// applies the sign at the end and holds the result on the writeback channel
// until it is taken. Rename tags ride along unchanged.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset
//   io         mul_x_unit_if.slave (issue d_* and writeback w_* channels)
//   dbg_state  current FSM state (0 IDLE, 1 CALC, 2 DONE)
//
// Build option: define MUL_X_EARLY_OUT_EN to skip the CALC phase when either
// operand magnitude is zero (result is then presented one cycle after accept).
module mul_x_unit #(
  parameter int p_seq_num_bits   = 5,
  parameter int p_phys_addr_bits = 6,
  parameter int p_bits_per_cycle = 4
) (
  input  logic        clk,
  input  logic        rst,
  mul_x_unit_if.slave io,
  output logic [1:0]  dbg_state
);
  localparam int B = p_bits_per_cycle;
  localparam int N = 32 / p_bits_per_cycle;
  localparam logic [5:0] N_CNT = 6'(N);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_e;

  state_e                      state_q, state_d;
  logic [5:0]                  count_q, count_d;
  logic [63:0]                 acc_q, acc_d;
  logic [31:0]                 mcand_q, mcand_d;
  logic [31:0]                 mplier_q, mplier_d;
  logic                        neg_q, neg_d;
  logic [1:0]                  func_q, func_d;
  logic [31:0]                 pc_q, pc_d;
  logic [4:0]                  waddr_q, waddr_d;
  logic [p_seq_num_bits-1:0]   seq_q, seq_d;
  logic [p_phys_addr_bits-1:0] preg_q, preg_d;
  logic [p_phys_addr_bits-1:0] ppreg_q, ppreg_d;

  // operand sign handling at accept
  logic        sgn1, sgn2;
  logic [31:0] mag1, mag2;
  // one shift-add step
  logic [31+B:0] partial;
  logic [63+B:0] sum;
  // signed product
  logic [63:0] prod;

  always_comb begin
    // op1 is signed for all but MULHU; op2 is signed only for MUL/MULH.
    sgn1 = (io.d_func != 2'b11) & io.d_op1[31];
    sgn2 = (io.d_func[1] == 1'b0) & io.d_op2[31];
    mag1 = sgn1 ? (~io.d_op1 + 32'd1) : io.d_op1;
    mag2 = sgn2 ? (~io.d_op2 + 32'd1) : io.d_op2;
  end

  // The partial product lands at bit 32 of a window that then shifts right by
  // B; after N steps chunk i sits at weight 2^(B*i), i.e. the exact product.
  always_comb begin
    partial = (32+B)'(mcand_q) * (32+B)'(mplier_q[B-1:0]);
    sum     = {{B{1'b0}}, acc_q} + {partial, 32'd0};
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    func_d   = func_q;
    pc_d     = pc_q;
    waddr_d  = waddr_q;
    seq_d    = seq_q;
    preg_d   = preg_q;
    ppreg_d  = ppreg_q;
    case (state_q)
      S_IDLE: begin
        if (io.d_val) begin
          mcand_d  = mag1;
          mplier_d = mag2;
          neg_d    = sgn1 ^ sgn2;
          func_d   = io.d_func;
          pc_d     = io.d_pc;
          waddr_d  = io.d_waddr;
          seq_d    = io.d_seq_num;
          preg_d   = io.d_preg;
          ppreg_d  = io.d_ppreg;
          acc_d    = 64'd0;
          count_d  = N_CNT;
          state_d  = S_CALC;
`ifdef MUL_X_EARLY_OUT_EN
          if (mag1 == 32'd0 || mag2 == 32'd0) state_d = S_DONE;
`endif
        end
      end
      S_CALC: begin
        acc_d    = 64'(sum >> B);
        mplier_d = mplier_q >> B;
        count_d  = count_q - 6'd1;
        if (count_q == 6'd1) state_d = S_DONE;
      end
      S_DONE: begin
        if (io.w_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      func_q   <= '0;
      pc_q     <= '0;
      waddr_q  <= '0;
      seq_q    <= '0;
      preg_q   <= '0;
      ppreg_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      func_q   <= func_d;
      pc_q     <= pc_d;
      waddr_q  <= waddr_d;
      seq_q    <= seq_d;
      preg_q   <= preg_d;
      ppreg_q  <= ppreg_d;
    end
  end

  // Outputs derive only from flops, so they hold steady while DONE stalls.
  always_comb begin
    prod = neg_q ? (~acc_q + 64'd1) : acc_q;
  end

  assign io.d_rdy     = (state_q == S_IDLE);
  assign io.w_val     = (state_q == S_DONE);
  assign io.w_wdata   = (func_q == 2'b00) ? prod[31:0] : prod[63:32];
  assign io.w_wen     = (waddr_q != 5'd0);
  assign io.w_pc      = pc_q;
  assign io.w_waddr   = waddr_q;
  assign io.w_seq_num = seq_q;
  assign io.w_preg    = preg_q;
  assign io.w_ppreg   = ppreg_q;
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_mul_x_unit.sv
`timescale 1ns/1ps
module tb_mul_x_unit;
  localparam int SN = 5;
  localparam int PA = 6;
  localparam int N  = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  mul_x_unit_if #(.p_seq_num_bits(SN), .p_phys_addr_bits(PA)) bus ();

  mul_x_unit #(
    .p_seq_num_bits(SN), .p_phys_addr_bits(PA), .p_bits_per_cycle(4)
  ) dut (
    .clk(clk), .rst(rst), .io(bus), .dbg_state(dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [1:0]    func;
    logic [31:0]   op1;
    logic [31:0]   op2;
    logic [4:0]    waddr;
    logic [SN-1:0] seq;
    logic [PA-1:0] preg;
    logic [PA-1:0] ppreg;
    logic [31:0]   exp_wdata;
  } vec_t;

  logic [31:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] tagv(input logic [31:0] pc, input logic [4:0] wa,
                                       input logic [SN-1:0] sq, input logic [PA-1:0] pr,
                                       input logic [PA-1:0] ppr);
    return 64'({pc, wa, sq, pr, ppr});
  endfunction

  // ---------------- driver tasks ----------------
  // Presents an op at a falling edge once d_rdy is high; returns 1ns after
  // the accepting rising edge with d_val dropped.
  task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [4:0] wa, input logic [SN-1:0] sq,
                       input logic [PA-1:0] pr, input logic [PA-1:0] ppr);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.d_rdy && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.d_rdy) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: d_rdy=0, expected 1");
    end
    bus.d_val     = 1'b1;
    bus.d_func    = f;
    bus.d_op1     = a;
    bus.d_op2     = b;
    bus.d_pc      = pc;
    bus.d_waddr   = wa;
    bus.d_seq_num = sq;
    bus.d_preg    = pr;
    bus.d_ppreg   = ppr;
    @(posedge clk);
    #1;
    bus.d_val = 1'b0;
  endtask

  // Counts falling edges after the accept edge until w_val is seen; also
  // counts cycles where d_rdy was high while the op was still in flight.
  task automatic wait_result(output int lat, output int busy_rdy);
    lat = 0;
    busy_rdy = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!bus.w_val && bus.d_rdy) busy_rdy++;
    end while (!bus.w_val && lat < 40);
    if (!bus.w_val) begin
      n_vec++;
      n_err++;
      $display("FAIL result_timeout: w_val=0 after %0d cycles, expected 1", lat);
    end
  endtask

  task automatic run_vector(input string nm, input vec_t v, input logic [31:0] pc);
    int lat, busy, exp_lat;
    exp_q.push_back(v.exp_wdata);
    issue(v.func, v.op1, v.op2, pc, v.waddr, v.seq, v.preg, v.ppreg);
    wait_result(lat, busy);
    exp_lat = N + 1;
`ifdef MUL_X_EARLY_OUT_EN
    if (v.op1 == 32'd0 || v.op2 == 32'd0) exp_lat = 1;
`endif
    check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    check({nm, "_busy_rdy"}, 64'(busy), 64'd0);
    check({nm, "_wdata"}, 64'(bus.w_wdata), 64'(exp_q.pop_front()));
    check({nm, "_wen"}, 64'(bus.w_wen), 64'(v.waddr != 5'd0));
    check({nm, "_tags"}, tagv(bus.w_pc, bus.w_waddr, bus.w_seq_num, bus.w_preg, bus.w_ppreg),
          tagv(pc, v.waddr, v.seq, v.preg, v.ppreg));
    // w_rdy is high here, so the result is taken on this edge
    @(posedge clk);
    #1;
  endtask

  // ---------------- test ----------------
  vec_t vecs[14];
  vec_t v;
  int   lat, busy, wv_cnt;

  initial begin
    vecs[0]  = '{2'b00, 32'd7,         32'd6,         5'd1,  5'd1, 6'd1, 6'd2, 32'h0000002A};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd2,  5'd2, 6'd3, 6'd4, 32'h00000000};
    vecs[2]  = '{2'b10, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd3,  5'd3, 6'd5, 6'd6, 32'hFFFFFFFF};
    vecs[3]  = '{2'b11, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd4,  5'd4, 6'd7, 6'd8, 32'hFFFFFFFE};
    vecs[4]  = '{2'b00, 32'h12345678,  32'h9ABCDEF0,  5'd0,  5'd9, 6'd5, 6'd3, 32'h242D2080};
    vecs[5]  = '{2'b01, 32'h80000000,  32'h80000000,  5'd5,  5'd10, 6'd9, 6'd1, 32'h40000000};
    vecs[6]  = '{2'b00, 32'h80000000,  32'hFFFFFFFF,  5'd6,  5'd11, 6'd2, 6'd0, 32'h80000000};
    vecs[7]  = '{2'b11, 32'h80000000,  32'd2,         5'd7,  5'd12, 6'd4, 6'd3, 32'h00000001};
    vecs[8]  = '{2'b00, 32'hFFFFFFFE,  32'd3,         5'd8,  5'd13, 6'd6, 6'd5, 32'hFFFFFFFA};
    vecs[9]  = '{2'b10, 32'h80000000,  32'h80000000,  5'd9,  5'd14, 6'd8, 6'd7, 32'hC0000000};
    vecs[10] = '{2'b01, 32'h7FFFFFFF,  32'h7FFFFFFF,  5'd10, 5'd15, 6'd10, 6'd9, 32'h3FFFFFFF};
    vecs[11] = '{2'b01, 32'hFFFFFFFF,  32'd5,         5'd11, 5'd16, 6'd12, 6'd11, 32'hFFFFFFFF};
    vecs[12] = '{2'b00, 32'd0,         32'hDEADBEEF,  5'd12, 5'd17, 6'd14, 6'd13, 32'h00000000};
    vecs[13] = '{2'b11, 32'hDEADBEEF,  32'd0,         5'd13, 5'd18, 6'd16, 6'd15, 32'h00000000};

    bus.d_val = 1'b0; bus.d_func = 2'b00; bus.d_op1 = '0; bus.d_op2 = '0;
    bus.d_pc = '0; bus.d_waddr = '0; bus.d_seq_num = '0; bus.d_preg = '0; bus.d_ppreg = '0;
    bus.w_rdy = 1'b1;

    // reset state, sampled while reset is held
    repeat (2) @(negedge clk);
    check("rst_d_rdy", 64'(bus.d_rdy), 64'd1);
    check("rst_w_val", 64'(bus.w_val), 64'd0);
    check("rst_w_wen", 64'(bus.w_wen), 64'd0);
    check("rst_w_wdata", 64'(bus.w_wdata), 64'd0);
    check("rst_tags", tagv(bus.w_pc, bus.w_waddr, bus.w_seq_num, bus.w_preg, bus.w_ppreg), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 14; i++)
      run_vector($sformatf("v%0d", i), vecs[i], 32'h1000 + 32'(i * 4));

    // backpressure: result held for 5 cycles while the next op waits
    bus.w_rdy = 1'b0;
    exp_q.push_back(32'd12);
    issue(2'b00, 32'd3, 32'd4, 32'h2000, 5'd7, 5'd1, 6'd10, 6'd11);
    wait_result(lat, busy);
    check("bp_latency", 64'(lat), 64'(N + 1));
    bus.d_val = 1'b1; bus.d_func = 2'b11; bus.d_op2 = 32'h00010000;
    bus.d_pc = 32'h2004; bus.d_waddr = 5'd8; bus.d_seq_num = 5'd2;
    bus.d_preg = 6'd12; bus.d_ppreg = 6'd13;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d_w_val", k), 64'(bus.w_val), 64'd1);
      check($sformatf("bp%0d_d_rdy", k), 64'(bus.d_rdy), 64'd0);
      check($sformatf("bp%0d_wdata", k), 64'(bus.w_wdata), 64'(exp_q[0]));
      check($sformatf("bp%0d_tags", k),
            tagv(bus.w_pc, bus.w_waddr, bus.w_seq_num, bus.w_preg, bus.w_ppreg),
            tagv(32'h2000, 5'd7, 5'd1, 6'd10, 6'd11));
      bus.d_op1 = $urandom_range(32'hFFFFFFF0, 32'h1);
      @(negedge clk);
    end
    void'(exp_q.pop_front());
    bus.d_op1 = 32'h00010000;
    bus.w_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_w_val", 64'(bus.w_val), 64'd0);
    check("bp_idle_d_rdy", 64'(bus.d_rdy), 64'd1);
    @(posedge clk);
    #1;
    bus.d_val = 1'b0;
    exp_q.push_back(32'h00000001);
    wait_result(lat, busy);
    check("bp_next_latency", 64'(lat), 64'(N + 1));
    check("bp_next_wdata", 64'(bus.w_wdata), 64'(exp_q.pop_front()));
    check("bp_next_tags", tagv(bus.w_pc, bus.w_waddr, bus.w_seq_num, bus.w_preg, bus.w_ppreg),
          tagv(32'h2004, 5'd8, 5'd2, 6'd12, 6'd13));
    @(posedge clk);
    #1;

    // reset during CALC cycle 3: op must vanish
    issue(2'b00, 32'd9, 32'd9, 32'h3000, 5'd3, 5'd3, 6'd3, 6'd3);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_calc_d_rdy", 64'(bus.d_rdy), 64'd1);
    check("rst_calc_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    wv_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.w_val) wv_cnt++;
    end
    check("rst_calc_no_w_val", 64'(wv_cnt), 64'd0);
    check("rst_calc_d_rdy_after", 64'(bus.d_rdy), 64'd1);

    // reset while a result is stalled in DONE: w_val drops without a clock edge
    bus.w_rdy = 1'b0;
    issue(2'b00, 32'd2, 32'd2, 32'h3100, 5'd4, 5'd4, 6'd4, 6'd4);
    wait_result(lat, busy);
    check("rst_done_w_val_before", 64'(bus.w_val), 64'd1);
    rst = 1'b0;
    #1;
    check("rst_done_w_val_async", 64'(bus.w_val), 64'd0);
    check("rst_done_d_rdy_async", 64'(bus.d_rdy), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    bus.w_rdy = 1'b1;

    v = '{2'b00, 32'd3, 32'd5, 5'd5, 5'd20, 6'd21, 6'd22, 32'h0000000F};
    run_vector("post_rst", v, 32'h4000);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
